axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ==========================================================================
// axi_rd_arbiter : two-master round-robin AXI read arbiter, one outstanding
// transaction. Define ARB_PERF_CNT_EN to build the perf counters.  Rev 1.0
// ==========================================================================
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_wait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;

  logic sel;
  logic grant0;
  logic grant1;
  logic in_data;

  // rst_n gating keeps arready low while reset is held, even with arvalid high.
  always_comb begin
    if (m0_arvalid && m1_arvalid) sel = prio_q;
    else                          sel = m1_arvalid;
    grant0 = rst_n && (state_q == IDLE) && m0_arvalid && !sel;
    grant1 = rst_n && (state_q == IDLE) && m1_arvalid && sel;
  end

  assign in_data    = (state_q == DATA);
  assign m0_arready = grant0;
  assign m1_arready = grant1;

  assign s_arvalid  = arvalid_q;
  assign s_araddr   = araddr_q;
  assign s_arlen    = arlen_q;
  assign s_arsize   = arsize_q;
  assign s_arburst  = arburst_q;

  assign s_rready   = in_data && (owner_q ? m1_rready : m0_rready);
  assign m0_rvalid  = in_data && !owner_q && s_rvalid;
  assign m1_rvalid  = in_data &&  owner_q && s_rvalid;
  assign m0_rlast   = in_data && !owner_q && s_rlast;
  assign m1_rlast   = in_data &&  owner_q && s_rlast;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d   = grant1;
          araddr_d  = grant1 ? m1_araddr  : m0_araddr;
          arlen_d   = grant1 ? m1_arlen   : m0_arlen;
          arsize_d  = grant1 ? m1_arsize  : m0_arsize;
          arburst_d = grant1 ? m1_arburst : m0_arburst;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        // Priority passes to whichever master did not just finish.
        if (s_rvalid && s_rready && s_rlast) begin
          state_d = IDLE;
          prio_d  = !owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_grant0_d = perf_grant0_q;
    perf_grant1_d = perf_grant1_q;
    perf_wait_d   = perf_wait_q;
    if (grant0) perf_grant0_d = perf_grant0_q + 32'd1;
    if (grant1) perf_grant1_d = perf_grant1_q + 32'd1;
    if ((m0_arvalid && !grant0) || (m1_arvalid && !grant1))
      perf_wait_d = perf_wait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_wait_q   <= '0;
    end else begin
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_wait_q   <= perf_wait_d;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_wait   = perf_wait_q;
`else
  assign perf_grant0 = 32'd0;
  assign perf_grant1 = 32'd0;
  assign perf_wait   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_axi_rd_arbiter : directed + randomized bench for axi_rd_arbiter with a
// transaction-level reference model.  Rev 1.0
// ==========================================================================
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_arvalid = 0, m1_arvalid = 0, m0_rready = 0, m1_rready = 0;
  logic [ADDR_W-1:0] m0_araddr = '0, m1_araddr = '0;
  logic [7:0] m0_arlen = '0, m1_arlen = '0;
  logic [2:0] m0_arsize = '0, m1_arsize = '0;
  logic [1:0] m0_arburst = '0, m1_arburst = '0;
  logic s_arready = 0, s_rvalid = 0, s_rlast = 0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic s_arvalid, s_rready;
  logic [ADDR_W-1:0] s_araddr;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst;
  logic [31:0] perf_grant0, perf_grant1, perf_wait;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_wait(perf_wait)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus staged for the next cycle
  logic n0v, n1v, n0rr, n1rr, nsar, nsrv, nsrl;
  logic [ADDR_W-1:0] n0a, n1a;
  logic [7:0] n0l, n1l;
  logic [2:0] n0s, n1s;
  logic [1:0] n0b, n1b;
  logic [DATA_W-1:0] nsrd;

  // Reference model: 0 = free, 1 = request forwarded, 2 = returning data
  int          ph;
  logic        prio, own;
  logic [ADDR_W-1:0] x_addr;
  logic [7:0]  x_len;
  logic [2:0]  x_size;
  logic [1:0]  x_burst;
  int          beat;
  logic [31:0] g0, g1, wcnt;

  // Observed deliveries at master ports
  int obs0, obs1, obs0_last, obs1_last;
  logic m1_rv_seen, ar_seen;
  logic [DATA_W-1:0] obs1_data;

  task automatic model_reset();
    ph = 0; prio = 1'b0; own = 1'b0; beat = 0;
    g0 = '0; g1 = '0; wcnt = '0;
  endtask

  task automatic clear_stim();
    n0v = 0; n1v = 0; n0rr = 1; n1rr = 1; nsar = 1; nsrv = 1; nsrl = 0;
    n0a = '0; n1a = '0; n0l = '0; n1l = '0; n0s = 3'd2; n1s = 3'd2;
    n0b = 2'd1; n1b = 2'd1; nsrd = '0;
  endtask

  task automatic clear_obs();
    obs0 = 0; obs1 = 0; obs0_last = 0; obs1_last = 0;
    m1_rv_seen = 0; ar_seen = 0; obs1_data = '0;
  endtask

  task automatic step();
    logic e0, e1, esr, erv0, erv1;
    @(negedge clk);
    m0_arvalid = n0v; m0_araddr = n0a; m0_arlen = n0l; m0_arsize = n0s; m0_arburst = n0b;
    m1_arvalid = n1v; m1_araddr = n1a; m1_arlen = n1l; m1_arsize = n1s; m1_arburst = n1b;
    m0_rready = n0rr; m1_rready = n1rr; s_arready = nsar; s_rvalid = nsrv; s_rdata = nsrd;
    s_rlast = (ph == 2) ? (beat == int'(x_len)) : nsrl;
    #1;
    e0   = (ph == 0) && m0_arvalid && (!m1_arvalid || prio == 1'b0);
    e1   = (ph == 0) && m1_arvalid && (!m0_arvalid || prio == 1'b1);
    esr  = (ph == 2) && (own ? m1_rready : m0_rready);
    erv0 = (ph == 2) && !own && s_rvalid;
    erv1 = (ph == 2) &&  own && s_rvalid;
    check("m0_arready", m0_arready, e0);
    check("m1_arready", m1_arready, e1);
    check("s_arvalid", s_arvalid, ph == 1);
    if (ph == 1) begin
      check("s_araddr", s_araddr, x_addr);
      check("s_arlen", s_arlen, x_len);
      check("s_arsize", s_arsize, x_size);
      check("s_arburst", s_arburst, x_burst);
    end
    check("s_rready", s_rready, esr);
    check("m0_rvalid", m0_rvalid, erv0);
    check("m1_rvalid", m1_rvalid, erv1);
    if (erv0) begin
      check("m0_rdata", m0_rdata, s_rdata);
      check("m0_rlast", m0_rlast, s_rlast);
    end
    if (erv1) begin
      check("m1_rdata", m1_rdata, s_rdata);
      check("m1_rlast", m1_rlast, s_rlast);
    end
`ifdef ARB_PERF_CNT_EN
    check("perf_grant0", perf_grant0, g0);
    check("perf_grant1", perf_grant1, g1);
    check("perf_wait", perf_wait, wcnt);
`else
    check("perf_zero", {perf_grant0 | perf_grant1 | perf_wait}, 64'd0);
`endif
    if (m0_rvalid && m0_rready) begin obs0++; if (m0_rlast) obs0_last = obs0; end
    if (m1_rvalid && m1_rready) begin
      obs1++; obs1_data = m1_rdata;
      if (m1_rlast) obs1_last = obs1;
    end
    if (m1_rvalid) m1_rv_seen = 1'b1;
    if (m0_arready || m1_arready) ar_seen = 1'b1;
    // Model advance across the coming rising edge
    if ((m0_arvalid && !e0) || (m1_arvalid && !e1)) wcnt = wcnt + 32'd1;
    case (ph)
      0: if (e0 || e1) begin
        own     = e1;
        x_addr  = e1 ? m1_araddr  : m0_araddr;
        x_len   = e1 ? m1_arlen   : m0_arlen;
        x_size  = e1 ? m1_arsize  : m0_arsize;
        x_burst = e1 ? m1_arburst : m0_arburst;
        if (e1) g1 = g1 + 32'd1; else g0 = g0 + 32'd1;
        ph = 1;
      end
      1: if (s_arready) begin ph = 2; beat = 0; end
      2: if (s_rvalid && esr) begin
        if (s_rlast) begin ph = 0; prio = !own; end
        else beat++;
      end
      default: ph = 0;
    endcase
  endtask

  task automatic finish_txn(input string tag);
    for (int i = 0; i < 60 && ph != 0; i++) step();
    check(tag, ph, 0);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_stim();
    clear_obs();
    model_reset();
    m0_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready0", m0_arready, 0);
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_s_arlen", {s_arlen, s_arsize, s_arburst}, 0);
    check("rst_perf", {perf_grant0 | perf_grant1 | perf_wait}, 0);
    m0_arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both request straight out of reset: m0, then m1, then m0 again
    n0v = 1; n0a = 32'h0000_1000; n0l = 8'd1;
    n1v = 1; n1a = 32'h0000_2000; n1l = 8'd0;
    step();
    check("rr_m0_first", m0_arready, 1);
    check("rr_m1_held", m1_arready, 0);
    n0v = 0;
    finish_txn("rr_m0_done");
    step();
    check("rr_m1_next", m1_arready, 1);
    n1v = 0;
    finish_txn("rr_m1_done");
    n0v = 1; n1v = 1;
    step();
    check("rr_m0_third", m0_arready, 1);
    check("rr_m1_third", m1_arready, 0);
    n0v = 0; n1v = 0;
    step();
`ifdef ARB_PERF_CNT_EN
    check("perf_g0_rr", perf_grant0, 2);
    check("perf_g1_rr", perf_grant1, 1);
    check("perf_wait_rr", perf_wait, 5);
`else
    check("perf_off_rr", {perf_grant0 | perf_grant1 | perf_wait}, 0);
`endif
    finish_txn("rr_third_done");

    // Single m0 four-beat burst
    clear_obs();
    n0v = 1; n0a = 32'h8000_0010; n0l = 8'd3;
    step();
    n0v = 0;
    step();
    check("b4_s_araddr", s_araddr, 32'h8000_0010);
    finish_txn("b4_done");
    check("b4_beats", obs0, 4);
    check("b4_last_idx", obs0_last, 4);
    check("b4_m1_quiet", m1_rv_seen, 0);

    // Slave stalls the address channel for 5 cycles
    clear_obs();
    n0v = 1; n0a = 32'h1234_5678; n0l = 8'd0; n0s = 3'd1; n0b = 2'd2;
    step();
    n0v = 0; n1v = 1; n1a = 32'h5555_0000; nsar = 0; nsrl = 1;
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_arvalid", s_arvalid, 1);
      check("stall_araddr", s_araddr, 32'h1234_5678);
    end
    check("stall_no_arready", ar_seen, 0);
    n1v = 0; nsar = 1; n0s = 3'd2; n0b = 2'd1;
    finish_txn("stall_done");

    // m1 single beat with rready held off
    clear_obs();
    n1v = 1; n1a = 32'h0000_0040; n1l = 8'd0;
    step();
    n1v = 0; nsrv = 0;
    step();
    nsrv = 1; nsrd = 32'hDEAD_BEEF; n1rr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_s_rready", s_rready, 0);
    end
    n1rr = 1;
    step();
    check("hold_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("hold_m1_rlast", m1_rlast, 1);
    step();
    check("hold_once", obs1, 1);
    check("hold_data", obs1_data, 32'hDEAD_BEEF);
    check("hold_idle_rvalid", m1_rvalid, 0);

    // Reset during beat 2 of 4
    n0v = 1; n0a = 32'h0000_0100; n0l = 8'd3; nsrd = 32'h0000_0001;
    step();
    n0v = 0;
    step();
    step();
    @(negedge clk);
    s_rvalid = 1'b1; s_rlast = 1'b0;
    #1;
    check("mid_beat2_live", m0_rvalid, 1);
    #2;
    rst_n = 1'b0; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    #1;
    check("mid_rst_ready", {m0_arready, m1_arready, s_rready}, 0);
    check("mid_rst_valid", {m0_rvalid, m1_rvalid, s_arvalid}, 0);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    hold_reset();
    n1v = 1; n1a = 32'h0000_0200; n1l = 8'd1;
    step();
    check("post_rst_grant", m1_arready, 1);
    n1v = 0;
    finish_txn("post_rst_done");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      n0v  = 1'($urandom_range(0, 1));
      n1v  = 1'($urandom_range(0, 1));
      n0a  = $urandom; n1a = $urandom;
      n0l  = 8'($urandom_range(0, 3)); n1l = 8'($urandom_range(0, 3));
      n0s  = 3'($urandom_range(0, 7)); n1s = 3'($urandom_range(0, 7));
      n0b  = 2'($urandom_range(0, 3)); n1b = 2'($urandom_range(0, 3));
      n0rr = ($urandom_range(0, 3) != 0);
      n1rr = ($urandom_range(0, 3) != 0);
      nsar = 1'($urandom_range(0, 1));
      nsrv = ($urandom_range(0, 2) != 0);
      nsrd = $urandom;
      nsrl = 1'($urandom_range(0, 1));
      step();
    end
    clear_stim();
    finish_txn("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
